// File: rtl/ocp3_nic_pwr_scheduler_if.sv
// Slot-side signal bundle of the OCP3 NIC main-power scheduler.
// master = per-slot sequencers / rail monitors, slave = the scheduler.
interface ocp3_nic_pwr_scheduler_if #(
    parameter int NUM_SLOTS = 4
);
    logic [NUM_SLOTS-1:0] iREQ;
    logic [NUM_SLOTS-1:0] iPWRGD;
    logic [NUM_SLOTS-1:0] oPWR_EN;
    logic [NUM_SLOTS-1:0] oFAULT;

    modport master (
        output iREQ,
        output iPWRGD,
        input  oPWR_EN,
        input  oFAULT
    );

    modport slave (
        input  iREQ,
        input  iPWRGD,
        output oPWR_EN,
        output oFAULT
    );
endinterface

// File: rtl/ocp3_nic_pwr_scheduler.sv
// Round-robin staggered main-power enable for OCP3 NIC slots: one slot ramps at a time.
// Optional OCP3_SCHED_DBG_EN exposes the live FSM state and grant index on the debug outputs.
module ocp3_nic_pwr_scheduler #(
    parameter int                 NUM_SLOTS    = 4,
    parameter int                 TMR_W        = 16,
    parameter logic [TMR_W-1:0]   STAGGER_MS   = 16'd21,
    parameter logic [TMR_W-1:0]   PWRGD_TMO_MS = 16'd105
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic                          iTick_1ms,
    ocp3_nic_pwr_scheduler_if.slave       bus,
    output logic                          oBUSY,
    output logic [1:0]                    oDBG_FSM_curr,
    output logic [2:0]                    oDBG_GNT_IDX
);

    localparam logic [1:0]           ST_IDLE    = 2'b00;
    localparam logic [1:0]           ST_SETTLE  = 2'b01;
    localparam logic [1:0]           ST_STAGGER = 2'b10;
    localparam logic [NUM_SLOTS-1:0] SLOT_ONE   = NUM_SLOTS'(1);
    localparam logic [NUM_SLOTS-1:0] SLOT_ZERO  = {NUM_SLOTS{1'b0}};
    localparam logic [2:0]           LAST_IDX   = 3'(NUM_SLOTS - 1);
    localparam logic [TMR_W-1:0]     CNT_ZERO   = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0]     CNT_ONE    = {{(TMR_W-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0]     CNT_MAX    = {TMR_W{1'b1}};

    logic [1:0]           r_state;
    logic [2:0]           r_ptr;
    logic [2:0]           r_gnt_idx;
    logic [TMR_W-1:0]     r_cnt;
    logic [NUM_SLOTS-1:0] r_pwr_en;
    logic [NUM_SLOTS-1:0] r_fault;
    logic                 r_busy;

    logic [1:0]           w_state_nxt;
    logic [2:0]           w_ptr_nxt;
    logic [2:0]           w_gnt_nxt;
    logic [TMR_W-1:0]     w_cnt_nxt;
    logic [TMR_W-1:0]     w_cnt_inc;
    logic [NUM_SLOTS-1:0] w_en_nxt;
    logic [NUM_SLOTS-1:0] w_fault_nxt;
    logic [NUM_SLOTS-1:0] w_pending;
    logic [NUM_SLOTS-1:0] w_gnt_oh;
    logic [NUM_SLOTS-1:0] w_sel_oh;
    logic [NUM_SLOTS-1:0] w_settle_oh;
    logic [NUM_SLOTS-1:0] w_pg_loss;
    logic [3:0]           w_cand;
    logic                 w_hit;
    logic                 w_found;
    logic [2:0]           w_sel_idx;

    assign w_pending = bus.iREQ & ~r_pwr_en & ~r_fault;
    assign w_gnt_oh  = SLOT_ONE << r_gnt_idx;
    assign w_sel_oh  = SLOT_ONE << w_sel_idx;
    assign w_cnt_inc = (iTick_1ms && (r_cnt != CNT_MAX)) ? (r_cnt + CNT_ONE) : r_cnt;

    // First pending slot at or above the pointer, wrapping modulo NUM_SLOTS.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = 3'd0;
        w_cand    = 4'd0;
        w_hit     = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            w_cand    = {1'b0, r_ptr} + 4'(k);
            w_cand    = (w_cand >= 4'(NUM_SLOTS)) ? (w_cand - 4'(NUM_SLOTS)) : w_cand;
            w_hit     = ~w_found & (|(w_pending & (SLOT_ONE << w_cand)));
            w_sel_idx = w_hit ? w_cand[2:0] : w_sel_idx;
            w_found   = w_found | w_hit;
        end
    end

    // Next-state: release beats power-good beats timeout; pgood loss only hits settled slots.
    always_comb begin
        w_settle_oh = (r_state == ST_SETTLE) ? w_gnt_oh : SLOT_ZERO;
        w_pg_loss   = r_pwr_en & ~w_settle_oh & ~bus.iPWRGD & bus.iREQ;
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt_idx;
        w_cnt_nxt   = r_cnt;
        w_en_nxt    = r_pwr_en & bus.iREQ & ~w_pg_loss;
        w_fault_nxt = (r_fault | w_pg_loss) & bus.iREQ;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_en_nxt    = w_en_nxt | w_sel_oh;
                    w_gnt_nxt   = w_sel_idx;
                    w_ptr_nxt   = (w_sel_idx == LAST_IDX) ? 3'd0 : (w_sel_idx + 3'd1);
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (|(w_gnt_oh & ~bus.iREQ)) begin
                    w_state_nxt = ST_STAGGER;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (|(w_gnt_oh & bus.iPWRGD)) begin
                    w_state_nxt = ST_STAGGER;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt >= PWRGD_TMO_MS) begin
                    w_en_nxt    = w_en_nxt & ~w_gnt_oh;
                    w_fault_nxt = w_fault_nxt | w_gnt_oh;
                    w_state_nxt = ST_STAGGER;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            ST_STAGGER: begin
                if (r_cnt >= STAGGER_MS) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State, pointer, timer and per-slot output registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 3'd0;
            r_gnt_idx <= 3'd0;
            r_cnt     <= CNT_ZERO;
            r_pwr_en  <= SLOT_ZERO;
            r_fault   <= SLOT_ZERO;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt_idx <= w_gnt_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pwr_en  <= w_en_nxt;
            r_fault   <= w_fault_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.oPWR_EN = r_pwr_en;
    assign bus.oFAULT  = r_fault;
    assign oBUSY       = r_busy;

`ifdef OCP3_SCHED_DBG_EN
    assign oDBG_FSM_curr = r_state;
    assign oDBG_GNT_IDX  = r_gnt_idx;
`else
    assign oDBG_FSM_curr = 2'b00;
    assign oDBG_GNT_IDX  = 3'b000;
`endif

endmodule

// File: tb/tb_ocp3_nic_pwr_scheduler.sv
// Scoreboard bench for ocp3_nic_pwr_scheduler: expected outputs are queued as stimulus
// is applied and popped when the DUT is sampled on the falling clock edge.
module tb_ocp3_nic_pwr_scheduler;

    typedef struct {
        string      tag;
        logic [3:0] en;
        logic [3:0] flt;
        logic       busy;
    } exp_t;

    logic       iClk;
    logic       iRst;
    logic       tick;
    logic       busy;
    logic [1:0] dbg_fsm;
    logic [2:0] dbg_idx;
    int         tb_ticks;
    int         tcnt;
    int         n_checks;
    int         n_pass;
    exp_t       sb_q[$];
    int         order_q[$];

    ocp3_nic_pwr_scheduler_if #(.NUM_SLOTS(4)) bus ();

    ocp3_nic_pwr_scheduler #(
        .NUM_SLOTS    (4),
        .TMR_W        (16),
        .STAGGER_MS   (16'd21),
        .PWRGD_TMO_MS (16'd105)
    ) dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iTick_1ms     (tick),
        .bus           (bus),
        .oBUSY         (busy),
        .oDBG_FSM_curr (dbg_fsm),
        .oDBG_GNT_IDX  (dbg_idx)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // 1 ms strobe compressed to one pulse every 4 clocks, changed 2 units after posedge.
    initial begin
        tick     = 1'b0;
        tcnt     = 0;
        tb_ticks = 0;
        forever begin
            @(posedge iClk);
            #2;
            tcnt = (tcnt == 3) ? 0 : tcnt + 1;
            tick = (tcnt == 0);
            if (tick) tb_ticks++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic sb_push(input string tag, input logic [3:0] en, input logic [3:0] flt, input logic b);
        exp_t e;
        e.tag  = tag;
        e.en   = en;
        e.flt  = flt;
        e.busy = b;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        check_val("sb_not_empty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_val({e.tag, "_en"},   32'(bus.oPWR_EN), 32'(e.en));
            check_val({e.tag, "_flt"},  32'(bus.oFAULT),  32'(e.flt));
            check_val({e.tag, "_busy"}, 32'(busy),        32'(e.busy));
        end
    endtask

    task automatic do_reset();
        iRst       = 1'b1;
        bus.iREQ   = 4'b0000;
        bus.iPWRGD = 4'b0000;
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        seen = 0;
        for (int g = 0; g < 5000 && seen < n; g++) begin
            @(negedge iClk);
            if (tick) seen++;
        end
    endtask

    // Counts ticks consumed while busy, starting at the current negedge.
    task automatic count_idle(input string tag, output int n);
        bit done;
        n    = 0;
        done = 1'b0;
        for (int g = 0; g < 3000 && !done; g++) begin
            if (!busy) done = 1'b1;
            else begin
                if (tick) n++;
                @(negedge iClk);
            end
        end
        check_val({tag, "_idle_reached"}, 32'(done), 32'd1);
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] prev, output logic [3:0] nb);
        bit done;
        done = 1'b0;
        nb   = 4'b0000;
        for (int g = 0; g < 1500 && !done; g++) begin
            @(negedge iClk);
            nb = bus.oPWR_EN & ~prev;
            if (nb != 4'b0000) done = 1'b1;
        end
        check_val({tag, "_grant_seen"}, 32'(done), 32'd1);
    endtask

    task automatic count_until_fault(input int slot, output int n);
        bit done;
        n    = 0;
        done = 1'b0;
        for (int g = 0; g < 3000 && !done; g++) begin
            @(negedge iClk);
            if (bus.oFAULT[slot]) done = 1'b1;
            else if (tick) n++;
        end
        check_val("tmo_fault_seen", 32'(done), 32'd1);
    endtask

    initial begin
        logic [3:0] nb;
        logic [3:0] prev;
        int         n;
        int         last_t;
        n_checks = 0;
        n_pass   = 0;
        iRst       = 1'b1;
        bus.iREQ   = 4'b0000;
        bus.iPWRGD = 4'b0000;
        repeat (3) @(negedge iClk);
        sb_push("rst", 4'b0000, 4'b0000, 1'b0);
        sb_check();
        check_val("rst_dbg_fsm", 32'(dbg_fsm), 32'd0);
        check_val("rst_dbg_idx", 32'(dbg_idx), 32'd0);
        iRst = 1'b0;

        // Single slot: one-cycle grant, pgood at tick 5, 21-tick gap.
        @(negedge iClk);
        bus.iREQ = 4'b0001;
        sb_push("t1_grant", 4'b0001, 4'b0000, 1'b1);
        @(negedge iClk);
        sb_check();
        wait_ticks(5);
        bus.iPWRGD = 4'b0001;
        @(negedge iClk);
        count_idle("t1", n);
        check_val("t1_stagger_ticks", 32'(n), 32'd21);
        sb_push("t1_done", 4'b0001, 4'b0000, 1'b0);
        sb_check();
        bus.iREQ   = 4'b0000;
        bus.iPWRGD = 4'b0000;
        sb_push("t1_release", 4'b0000, 4'b0000, 1'b0);
        @(negedge iClk);
        sb_check();

        // All four at once: round-robin order, spacing, one settling slot.
        do_reset();
        bus.iREQ = 4'b1111;
        for (int s = 0; s < 4; s++) order_q.push_back(s);
        prev   = 4'b0000;
        last_t = 0;
        for (int s = 0; s < 4; s++) begin
            wait_grant("t2", prev, nb);
            n = order_q.pop_front();
            check_val("t2_order", 32'(nb), 32'(4'b0001 << n));
            check_val("t2_one_settling", 32'($countones(bus.oPWR_EN & ~bus.iPWRGD)), 32'd1);
            if (s > 0) check_val("t2_gap_ge24", 32'((tb_ticks - last_t) >= 24), 32'd1);
            last_t = tb_ticks;
            prev   = bus.oPWR_EN;
            wait_ticks(3);
            bus.iPWRGD = bus.iPWRGD | nb;
        end
        @(negedge iClk);
        count_idle("t2", n);
        sb_push("t2_all_on", 4'b1111, 4'b0000, 1'b0);
        sb_check();

        // Power-good timeout, fault clear on release, re-grant.
        do_reset();
        bus.iREQ = 4'b0100;
        sb_push("t3_grant", 4'b0100, 4'b0000, 1'b1);
        @(negedge iClk);
        sb_check();
        count_until_fault(2, n);
        check_val("t3_tmo_ticks", 32'(n), 32'd105);
        sb_push("t3_tmo", 4'b0000, 4'b0100, 1'b1);
        sb_check();
        bus.iREQ = 4'b0000;
        sb_push("t3_clear", 4'b0000, 4'b0000, 1'b1);
        @(negedge iClk);
        sb_check();
        bus.iREQ = 4'b0100;
        wait_grant("t3_re", 4'b0000, nb);
        sb_push("t3_regrant", 4'b0100, 4'b0000, 1'b1);
        sb_check();

        // Settled slot 1 loses power-good; slot 0 untouched.
        do_reset();
        bus.iREQ = 4'b0011;
        wait_grant("t4_a", 4'b0000, nb);
        bus.iPWRGD = 4'b0001;
        wait_grant("t4_b", 4'b0001, nb);
        check_val("t4_second", 32'(nb), 32'(4'b0010));
        bus.iPWRGD = 4'b0011;
        @(negedge iClk);
        count_idle("t4", n);
        bus.iPWRGD = 4'b0001;
        sb_push("t4_pgloss", 4'b0001, 4'b0010, 1'b0);
        @(negedge iClk);
        sb_check();

        // Release and pgood in the same cycle while settling.
        do_reset();
        bus.iREQ = 4'b0001;
        sb_push("t5_grant", 4'b0001, 4'b0000, 1'b1);
        @(negedge iClk);
        sb_check();
        wait_ticks(2);
        bus.iREQ   = 4'b0000;
        bus.iPWRGD = 4'b0001;
        sb_push("t5_release", 4'b0000, 4'b0000, 1'b1);
        @(negedge iClk);
        sb_check();
        count_idle("t5", n);
        check_val("t5_stagger_ticks", 32'(n), 32'd21);

        // Asynchronous reset while slot 3 settles.
        do_reset();
        bus.iREQ = 4'b1000;
        sb_push("t6_grant", 4'b1000, 4'b0000, 1'b1);
        @(negedge iClk);
        sb_check();
        wait_ticks(1);
        #2 iRst = 1'b1;
        #1;
        sb_push("t6_async", 4'b0000, 4'b0000, 1'b0);
        sb_check();
        repeat (2) @(negedge iClk);
        sb_push("t6_held", 4'b0000, 4'b0000, 1'b0);
        sb_check();
        iRst = 1'b0;
        sb_push("t6_regrant", 4'b1000, 4'b0000, 1'b1);
        @(negedge iClk);
        sb_check();

        // Pointer restarts at 0 after reset (slot 0 granted before reset moved it to 1).
        do_reset();
        bus.iREQ = 4'b0001;
        @(negedge iClk);
        wait_ticks(1);
        #2 iRst = 1'b1;
        bus.iREQ = 4'b0011;
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        sb_push("t7_ptr0", 4'b0001, 4'b0000, 1'b1);
        @(negedge iClk);
        sb_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ocp3_nic_pwr_scheduler.md
Name: ocp3_nic_pwr_scheduler

Overview:
Staggers main-power enable across up to NUM_SLOTS OCP3 NIC slots so that only one slot ramps at a time, which limits inrush on the shared 12V rail. Sits between the per-slot NIC sequencers and the main-power load switches. Each slot sequencer raises a request. The scheduler grants slots one at a time in round-robin order, waits for that slot's power-good, then enforces a stagger gap before the next grant. Timeouts and power-good loss are latched as per-slot faults.

Parameters:
NUM_SLOTS, 4, number of NIC slots arbitrated (2..8)
STAGGER_MS, 16'd21, minimum gap in 1 ms ticks after one slot settles before the next grant
PWRGD_TMO_MS, 16'd105, maximum 1 ms ticks from grant to power-good before the slot faults
TMR_W, 16, width of the internal tick counter

Ports:
iClk  input  1  module clock, 2 MHz
iRst  input  1  asynchronous, active-high reset
iTick_1ms  input  1  single-iClk-cycle strobe every 1 ms, synchronous to iClk
iREQ  input  NUM_SLOTS  per-slot main-power request, level
iPWRGD  input  NUM_SLOTS  per-slot main-rail power-good, already synchronised
oPWR_EN  output  NUM_SLOTS  per-slot main-power enable, registered
oFAULT  output  NUM_SLOTS  per-slot latched fault, registered
oBUSY  output  1  high whenever the FSM is not in IDLE
oDBG_FSM_curr  output  2  current FSM state encoding
oDBG_GNT_IDX  output  3  index of the slot currently granted or settling

Behaviour:
- Clock and reset: one clock, iClk. Reset iRst is asynchronous and active-high.
- Reset values: oPWR_EN=0, oFAULT=0, oBUSY=0, oDBG_FSM_curr=IDLE, oDBG_GNT_IDX=0, round-robin pointer=0, tick counter=0.
- Pending slot i: iREQ[i] & !oPWR_EN[i] & !oFAULT[i].
- States: IDLE=2'b00, SETTLE=2'b01, STAGGER=2'b10, unused 2'b11 returns to IDLE.
- IDLE, with any slot pending:
  - Select the first pending slot searching upward from the pointer, wrapping modulo NUM_SLOTS.
  - Next cycle: oPWR_EN[idx]=1, GNT_IDX=idx, pointer=idx+1 (wraps), counter=0, state=SETTLE.
  - Grant latency from request is 1 cycle.
- SETTLE:
  - Counter increments on iTick_1ms and saturates at all-ones.
  - iPWRGD[idx]=1 -> state=STAGGER, counter=0. oPWR_EN[idx] stays high.
  - Otherwise, when the counter is >= PWRGD_TMO_MS -> oPWR_EN[idx]=0, oFAULT[idx]=1, state=STAGGER, counter=0.
  - If power-good and timeout occur in the same cycle, power-good wins.
- STAGGER:
  - Counter increments on iTick_1ms.
  - When the counter is >= STAGGER_MS -> IDLE.
  - With STAGGER_MS=0, exit on the next cycle.
- Release (any state, any slot):
  - iREQ[i]=0 clears oPWR_EN[i] and oFAULT[i] on the next cycle.
  - If i is the settling slot, the FSM goes to STAGGER with counter=0; the gap is still enforced.
  - Release takes priority over power-good and timeout in the same cycle.
- Power-good loss:
  - Applies to a slot with oPWR_EN[i]=1 that is not currently settling, when iPWRGD[i]=0 is sampled.
  - Next cycle: oPWR_EN[i]=0, oFAULT[i]=1. The FSM is unaffected.
- Fault recovery: a faulted slot is never re-granted until its iREQ is deasserted for at least one cycle.
- oBUSY is registered and equals (state != IDLE).
- Reset mid-operation: all enables drop asynchronously. No grant is issued until reset is released and the arbitration restarts from pointer 0.

Optional Feature:
OCP3_SCHED_DBG_EN.
- Defined: oDBG_FSM_curr and oDBG_GNT_IDX are driven from the live FSM and grant index.
- Not defined: both outputs are tied to 0 and the debug logic is not synthesised.
- Scheduling behaviour is identical either way.

Test Plan:
- Reset then iREQ=4'b0001, iPWRGD[0] rises at tick 5 -> oPWR_EN=4'b0001 one cycle after the request; STAGGER lasts 21 ticks; oBUSY returns to 0.
- iREQ=4'b1111 in one cycle, each iPWRGD rises 3 ticks after its enable -> enables assert in order 0,1,2,3; successive grants are >=24 ticks apart; never two slots settling at once.
- iREQ[2]=1 with iPWRGD[2] held 0 -> at tick 105: oPWR_EN[2]=0, oFAULT[2]=1; then drop and re-raise iREQ[2] -> fault clears and the slot is re-granted.
- Slot 1 enabled and settled, then iPWRGD[1] forced 0 -> next cycle oPWR_EN[1]=0, oFAULT[1]=1; the other slots' enables are unchanged.
- iREQ[0] drops in the same cycle iPWRGD[0] rises during SETTLE -> oPWR_EN[0]=0, no fault, FSM enters STAGGER.
- iRst pulsed while slot 3 is settling -> all outputs 0 immediately; after release, iREQ=4'b1000 is granted with pointer starting at 0.
